ram_n_clr: RTL
==============

Name: ram_n_clr

Overview:
- Parametrised single-port RAM; successor to the fixed 16-bit x 8-word register-file RAM.
- Adds configurable word width and depth, a registered read port, and a hardware clear sequencer.
- Clear zeroes every word, one word per clock, after reset or on request.
- Used as the general data memory / scratch store in the datapath. The busy flag tells the controller when the array is usable.

Parameters:
- WIDTH, 16, data word width in bits (>=1).
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W words (ADDR_W >= 1).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in  input  WIDTH  write data.
- address  input  ADDR_W  read/write address.
- load  input  1  write enable; in is written to mem[address] on the rising edge.
- clear  input  1  request a full-array clear sweep.
- out  output  WIDTH  registered read data.
- out_valid  output  1  out holds data read from a valid, non-busy cycle.
- busy  output  1  clear sweep in progress; reads and writes are not accepted.

Behaviour:
- Reset, asynchronous, rst_n=0:
  - state=CLEAR, sweep pointer ptr=0.
  - out=0, out_valid=0, busy=1.
  - Array contents are undefined until the sweep completes.
- On rst_n release, the sweep starts on the first rising edge.
- States: CLEAR, IDLE.
- CLEAR:
  - Each edge writes 0 to mem[ptr], then ptr=ptr+1.
  - When ptr==DEPTH-1 is written, go to IDLE. ptr wraps to 0.
  - Sweep takes exactly DEPTH edges; busy=1 throughout, and busy drops on the edge that writes the last word.
  - load, address, in and clear are ignored; no user write lands during the sweep.
  - out=0, out_valid=0.
- IDLE:
  - busy=0.
  - Every edge: out <= mem[address] (1-cycle read latency), out_valid <= 1.
  - If load=1: mem[address] <= in on the same edge.
- Read-during-write, same address, same edge: out gets the NEW data (write-first).
- clear=1 in IDLE: go to CLEAR, ptr=0, busy=1 from the next edge.
  - That edge performs no write, even if load=1.
  - out <= 0, out_valid <= 0.
- clear=1 while already in CLEAR: ignored. The sweep is not restarted or extended.
- Reset mid-sweep or mid-operation: immediate return to CLEAR/ptr=0. The full sweep reruns.
- Address wrap: addresses are exactly ADDR_W bits, so there are no out-of-range accesses.
- No arithmetic on data. ptr is ADDR_W bits plus the terminal-count compare only.
- Data and the clear sweep share the single write port; they can never both write on one edge.

Test Plan:
- Reset then idle, WIDTH=16, ADDR_W=3:
  - Release rst_n with load=0.
  - Required: busy=1 for exactly 8 edges, then 0; out_valid rises one edge later.
  - Reading addresses 0..7 returns 0x0000 each, one cycle after the address is applied.
- Write/readback:
  - Write 0x0000@0, 0xFFFF@1, 0x00FF@2, 0xFF00@3, 0x0F0F@4, 0xF0F0@5, 0x3333@6, 0xCCCC@7.
  - Read back 0..7 with load=0. Required: out matches each value one cycle after its address.
- Load gating:
  - Hold load=0 with in=0xAAAA at address 2 after 0x00FF was stored.
  - Required: out stays 0x00FF.
- Read-during-write:
  - address=5, load=1, in=0x1234 on a single edge.
  - Required: out=0x1234 after that edge, not the old value 0xF0F0.
- Clear request:
  - With array loaded, pulse clear=1 together with load=1, in=0xBEEF, address=3.
  - Required: busy=1 for 8 edges, out_valid=0; load/clear pulses during the sweep have no effect.
  - Afterwards all words read 0x0000, including address 3 (no 0xBEEF).
- Async reset mid-sweep and parametrisation:
  - Assert rst_n=0 between clock edges during the sweep. Required: out=0 and busy=1 immediately, and a full 8-edge sweep follows.
  - Repeat the write/readback test with WIDTH=8, ADDR_W=4: 16 words, clear takes 16 edges, and word 15 holds 0xA5 when written.

Source files
------------

// File: rtl/ram_n_clr.sv
// Single-port RAM with a registered read port and a hardware clear sequencer.
// Every word is zeroed, one per clock, after reset or on request.
module ram_n_clr #(
   parameter int WIDTH  = 16,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [WIDTH-1:0]  in,
   input  logic [ADDR_W-1:0] address,
   input  logic              load,
   input  logic              clear,
   output logic [WIDTH-1:0]  out,
   output logic              out_valid,
   output logic              busy
);

   localparam int DEPTH = 2 ** ADDR_W;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_IDLE  = 1'b1
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic [ADDR_W-1:0]   ptr;
   logic                ptr_last;

   logic                wr_en;
   logic [ADDR_W-1:0]   wr_addr;
   logic [WIDTH-1:0]    wr_data;
   logic                rd_en;

   logic [WIDTH-1:0]    mem [DEPTH];

   // Write-first: a read of the address being written returns the new data.
   function automatic logic [WIDTH-1:0] rd_select(input logic              we,
                                                  input logic [WIDTH-1:0] wdata,
                                                  input logic [WIDTH-1:0] rdata);
      return we ? wdata : rdata;
   endfunction

   assign ptr_last = (ptr == ADDR_W'(DEPTH - 1));

   // ---- state register ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_CLEAR;
      end else begin
         state <= state_nxt;
      end
   end

   // ---- next-state logic ----
   always_comb begin
      state_nxt = state;
      case (state)
         ST_CLEAR: if (ptr_last) state_nxt = ST_IDLE;
         ST_IDLE:  if (clear)    state_nxt = ST_CLEAR;
         default:                state_nxt = ST_CLEAR;
      endcase
   end

   // ---- output / write-port decode ----
   always_comb begin
      busy    = 1'b0;
      wr_en   = 1'b0;
      wr_addr = address;
      wr_data = in;
      rd_en   = 1'b0;
      case (state)
         ST_CLEAR: begin
            busy    = 1'b1;
            wr_en   = 1'b1;
            wr_addr = ptr;
            wr_data = '0;
         end
         ST_IDLE: begin
            // A clear request owns the edge: no user write, no read.
            wr_en = load & ~clear;
            rd_en = ~clear;
         end
         default: begin
            busy = 1'b1;
         end
      endcase
   end

   // Sweep pointer only advances while clearing; it rests at 0 otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (state == ST_CLEAR) begin
         ptr <= ptr + 1'b1;
      end else begin
         ptr <= '0;
      end
   end

   // ---- storage array (single write port, no reset) ----
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // ---- registered read port ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out       <= '0;
         out_valid <= 1'b0;
      end else if (rd_en) begin
         out       <= rd_select(wr_en, wr_data, mem[address]);
         out_valid <= 1'b1;
      end else begin
         out       <= '0;
         out_valid <= 1'b0;
      end
   end

endmodule
